// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types and constants for the TRNG conditioner
// Purpose: extractor state encoding, byte/bit-count widths and default
//          parameter values used by trng_sync and trng_conditioner.
// Ports:   none (package).
package trng_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      SECOND = 2'd2,
      FAIL   = 2'd3
   } trng_state_t;

   localparam int BYTE_W    = 8;
   localparam int BIT_CNT_W = 3;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_SAMPLE_DIV  = 4;
   localparam int DEF_RCT_LIMIT   = 32;

endpackage

// File: rtl/trng_sync.sv
// rtl/trng_sync.sv - N-flop single-bit synchroniser
// Purpose: brings an asynchronous single-bit signal into the clk domain.
// Ports:   clk   - destination clock
//          rst_n - asynchronous active-low reset, clears all stages to 0
//          d_in  - asynchronous input bit
//          d_out - synchronised bit, N clocks behind d_in
module trng_sync #(
   parameter int N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic d_out
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[N-2:0], d_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q[N-1];

endmodule

// File: rtl/trng_conditioner.sv
// rtl/trng_conditioner.sv - ring-oscillator post-processing: sync, sample, debias, pack
// Purpose: synchronises the raw oscillator bit, samples it every SAMPLE_DIV
//          clocks, applies a von Neumann extractor, packs debiased bits into
//          bytes and runs a repetition-count health test.
// Ports:   clk         - system clock
//          rst_n       - asynchronous active-low reset
//          raw_bit     - ring-oscillator output (asynchronous)
//          enable      - run/stop control; low returns everything to idle
//          out_ready   - downstream accepts out_byte this cycle
//          out_valid   - out_byte holds a conditioned byte
//          out_byte    - conditioned byte
//          health_fail - sticky repetition-count failure flag
module trng_conditioner
   import trng_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
   parameter int RCT_LIMIT   = DEF_RCT_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              raw_bit,
   input  logic              enable,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [BYTE_W-1:0] out_byte,
   output logic              health_fail
);

   localparam logic [7:0] DIV_RELOAD = 8'(SAMPLE_DIV - 1);
   localparam logic [7:0] RCT_MAX    = 8'(RCT_LIMIT);

   logic sync_bit;

   trng_sync #(.N(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (raw_bit),
      .d_out (sync_bit)
   );

   trng_state_t          state_q, state_d;
   logic [7:0]           div_q,   div_d;
   logic                 first_q, first_d;
   logic                 prev_q,  prev_d;
   logic [7:0]           rct_q,   rct_d;
   logic [BYTE_W-1:0]    sr_q,    sr_d;
   logic [BIT_CNT_W-1:0] cnt_q,   cnt_d;
   logic [BYTE_W-1:0]    byte_q,  byte_d;
   logic                 valid_q, valid_d;
   logic                 fail_q,  fail_d;

   logic              running;
   logic              tick;
   logic [7:0]        rct_next;
   logic              trip;
   logic [BYTE_W-1:0] sr_shift;

   always_comb begin
      running  = (state_q == FIRST) || (state_q == SECOND);
      tick     = enable && running && (div_q == 8'd0);
      // rct_q == 0 means no sample has been taken since leaving IDLE
      rct_next = ((rct_q != 8'd0) && (sync_bit == prev_q)) ? rct_q + 8'd1 : 8'd1;
      trip     = tick && (rct_next == RCT_MAX);
      sr_shift = {sr_q[BYTE_W-2:0], first_q};

      state_d = state_q;
      div_d   = div_q;
      first_d = first_q;
      prev_d  = prev_q;
      rct_d   = rct_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      valid_d = valid_q;
      fail_d  = fail_q;

      if (!enable) begin
         state_d = IDLE;
         div_d   = '0;
         first_d = 1'b0;
         prev_d  = 1'b0;
         rct_d   = '0;
         sr_d    = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         fail_d  = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = FIRST;
         div_d   = DIV_RELOAD;
      end else begin
         // the divider keeps running in FAIL; its ticks are simply ignored there
         div_d = (div_q == 8'd0) ? DIV_RELOAD : div_q - 8'd1;
         if (valid_q && out_ready) begin
            valid_d = 1'b0;
         end
         if (tick) begin
            prev_d = sync_bit;
            rct_d  = rct_next;
            if (trip) begin
               state_d = FAIL;
               fail_d  = 1'b1;
               valid_d = 1'b0;
               sr_d    = '0;
               cnt_d   = '0;
            end else if (state_q == FIRST) begin
               first_d = sync_bit;
               state_d = SECOND;
            end else begin
               state_d = FIRST;
               if (sync_bit != first_q) begin
                  sr_d  = sr_shift;
                  cnt_d = cnt_q + 3'd1;
                  // a completed byte is only kept if the output slot is free
                  // or is being emptied in this same cycle
                  if ((cnt_q == 3'd7) && (!valid_q || out_ready)) begin
                     byte_d  = sr_shift;
                     valid_d = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         first_q <= 1'b0;
         prev_q  <= 1'b0;
         rct_q   <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         valid_q <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         first_q <= first_d;
         prev_q  <= prev_d;
         rct_q   <= rct_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         valid_q <= valid_d;
         fail_q  <= fail_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_byte    = byte_q;
   assign health_fail = fail_q;

endmodule

// File: doc/trng_conditioner.md
# trng_conditioner

Post-processing stage between the ring-oscillator entropy source and the chip outputs. It synchronises the raw asynchronous oscillator bit into `clk`, samples it at a fixed divided rate, and removes bias with a von Neumann extractor. Debiased bits are packed into bytes and offered on a valid/ready port. A repetition-count health test stops output when the source sticks at one value.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the raw-bit synchroniser; minimum 2.
- `SAMPLE_DIV`, 4: one sample taken every `SAMPLE_DIV` clocks; range 2..255.
- `RCT_LIMIT`, 32: this many consecutive identical raw samples trips the health failure; range 2..255.

Ports:
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous and active-low; all state is cleared.
- `raw_bit` in 1: ring-oscillator output, asynchronous to `clk`.
- `enable` in 1: run/stop control, synchronous.
- `out_ready` in 1: downstream accepts `out_byte` this cycle.
- `out_valid` out 1: `out_byte` holds a conditioned byte.
- `out_byte` out 8: conditioned byte.
- `health_fail` out 1: sticky repetition-count failure flag.

## Operation
- Synchroniser: `raw_bit` passes through `SYNC_STAGES` flops to produce `sync_bit`. No other logic reads `raw_bit`.
- Sampler: a down-counter reloads to `SAMPLE_DIV-1`. A `tick` occurs when the counter reaches 0 while `enable` is 1. The sampled value is `sync_bit` at the tick.
- Extractor FSM, states:
  - IDLE: `enable` is 0.
  - FIRST: waiting for the first sample of a pair.
  - SECOND: holding the first sample, waiting for the second.
  - FAIL: health test tripped.
- FSM transitions:
  - IDLE→FIRST when `enable` rises.
  - FIRST→SECOND on a tick; store the sample in `first_s`.
  - SECOND→FIRST on a tick. If the sample differs from `first_s`, emit debiased bit = `first_s`. If it is equal, emit nothing.
  - Any state→IDLE when `enable` is 0. IDLE clears the pair state, bit count, shift register, repetition counter, `health_fail` and `out_valid`.
  - Any running state→FAIL when the repetition counter reaches `RCT_LIMIT`.
- Packing:
  - Each emitted bit shifts into the LSB of an 8-bit shift register (`sr <= {sr[6:0], bit}`), and the 3-bit count increments.
  - When the 8th bit is emitted, `sr` with that bit is loaded into `out_byte` and the count wraps to 0.
- Output handshake:
  - A transfer occurs when `out_valid && out_ready`.
  - `out_byte` is stable while `out_valid` is 1 and `out_ready` is 0.
  - A byte completing while the output is occupied and not being accepted is discarded. The shift register and count still wrap.
  - A byte completing in the same cycle as a transfer reloads `out_byte`, and `out_valid` stays 1.
- Health test:
  - The repetition counter counts consecutive equal samples and resets to 1 when the sample changes.
  - On reaching `RCT_LIMIT`: `health_fail` is set, `out_valid` is forced to 0, any held byte is dropped, the shift register is cleared, and the FSM enters FAIL.
  - FAIL is left only via `enable` low or `rst_n`.

## Timing
- Reset values: `out_valid`=0, `out_byte`=0x00, `health_fail`=0. FSM is in IDLE, all counters are 0.
- Latency from `raw_bit` to `sync_bit`: `SYNC_STAGES` clocks.
- First tick comes `SAMPLE_DIV` clocks after the cycle in which `enable` is first sampled 1. After that, ticks come every `SAMPLE_DIV` clocks.
- `out_valid` rises one clock after the tick that emits the 8th bit.
- `health_fail` rises one clock after the tick that brings the counter to `RCT_LIMIT`. `out_valid` falls in that same cycle.
- Best-case throughput: 1 byte per 16 ticks.

## Structure
- Package `trng_pkg` holds:
  - the state enum (IDLE, FIRST, SECOND, FAIL);
  - the byte width (8) and the bit-count width (3);
  - default parameter constants.
- Sub-module `trng_sync`: a parameterised N-flop single-bit synchroniser with asynchronous active-low reset. It is reused by any other block that reads the oscillator.
- All remaining logic stays in `trng_conditioner`.

## Test plan
Raw-input patterns below are applied so that each value is stable across its sample tick; `SAMPLE_DIV`=4 unless stated.
- Alternating-pair byte: samples (1,0),(0,1) repeated 4 times, `out_ready`=1 → `out_byte`=0xAA and `out_valid` high for 1 cycle, one clock after the 16th tick.
- Equal pairs: samples (1,1),(0,0) for 20 pairs → no byte is emitted and `health_fail` stays 0.
- Backpressure:
  - 16 pairs giving 0xF0 then 0x0F, with `out_ready`=0 → `out_byte` holds 0xF0 and the second byte is dropped.
  - Then `out_ready`=1 for 1 cycle → `out_valid` falls.
- Simultaneous complete and accept: the 8th bit of the second byte is emitted in the same cycle as a transfer → `out_valid` stays 1 and `out_byte` shows the new value.
- Stuck source: `raw_bit` held at 1, `RCT_LIMIT`=32 → `health_fail`=1 one clock after the 32nd tick and `out_valid`=0. Toggling `enable` 1→0→1 clears the flag.
- Reset mid-operation: assert `rst_n`=0 after 5 emitted bits with a byte pending → all outputs are 0 immediately (asynchronously). After release, the next byte is built from fresh samples only.
